// File: rtl/im_loader.sv
// Streaming loader: header word then a burst of fields into the instruction memory.
// Optional trailing XOR checksum word when IM_LOAD_CHECKSUM_EN is defined.
module im_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int FIELDS     = 32,
   parameter int MEM_SIZE   = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic [31:0]           wr_addr_ext_im,
   output logic [DATA_WIDTH-1:0] wr_data_ext_im,
   output logic                  wr_en_ext_im,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int DEPTH = MEM_SIZE * FIELDS;

`ifdef IM_LOAD_CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      DATA   = 3'd2,
      CHECK  = 3'd3,
      FIN    = 3'd4
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HEADER = 3'd1,
      DATA   = 3'd2,
      FIN    = 3'd4
   } state_t;
`endif

   state_t state_q;
   state_t state_d;

   logic [15:0]           base_q;
   logic [15:0]           count_q;
   logic [15:0]           k_q;
   logic [15:0]           k_inc;
   logic [15:0]           hdr_base;
   logic [15:0]           hdr_cnt;
   logic                  range_bad;
   logic                  last;
   logic                  hdr_ld;
   logic                  wr_fire;
   logic                  err_set;
   logic                  err_clr;
   logic                  error_q;
   logic                  wr_en_q;
   logic [31:0]           wr_addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
`ifdef IM_LOAD_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q;
`endif

   assign hdr_base  = s_data[31:16];
   assign hdr_cnt   = s_data[15:0];
   assign range_bad = ({1'b0, hdr_base} + {1'b0, hdr_cnt}) > 17'(DEPTH);
   assign k_inc     = k_q + 16'd1;
   assign last      = (k_inc == count_q);
   assign err_clr   = (state_q == IDLE) && start;

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode and handshake/status outputs
   always_comb begin
      state_d = state_q;
      s_ready = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      hdr_ld  = 1'b0;
      wr_fire = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) state_d = HEADER;
         end
         HEADER: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) begin
               hdr_ld = 1'b1;
               if (range_bad) begin
                  err_set = 1'b1;
                  state_d = FIN;
               end else if (hdr_cnt == 16'd0) begin
`ifdef IM_LOAD_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = FIN;
`endif
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) begin
               wr_fire = 1'b1;
               if (last) begin
`ifdef IM_LOAD_CHECKSUM_EN
                  state_d = CHECK;
`else
                  state_d = FIN;
`endif
               end
            end
         end
`ifdef IM_LOAD_CHECKSUM_EN
         CHECK: begin
            s_ready = 1'b1;
            busy    = 1'b1;
            if (s_valid) begin
               err_set = (s_data != csum_q);
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Header capture, write port registers, field index and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         base_q    <= '0;
         count_q   <= '0;
         k_q       <= '0;
         error_q   <= 1'b0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
      end else begin
         wr_en_q <= wr_fire;
         if (hdr_ld) begin
            base_q  <= hdr_base;
            count_q <= hdr_cnt;
            k_q     <= '0;
         end
         if (wr_fire) begin
            wr_addr_q <= {16'd0, base_q} + {16'd0, k_q};
            wr_data_q <= s_data;
            k_q       <= k_inc;
         end
         if (err_clr)      error_q <= 1'b0;
         else if (err_set) error_q <= 1'b1;
      end
   end

`ifdef IM_LOAD_CHECKSUM_EN
   // Running XOR of the data words of the current load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       csum_q <= '0;
      else if (err_clr) csum_q <= '0;
      else if (wr_fire) csum_q <= csum_q ^ s_data;
   end
`endif

   assign wr_en_ext_im   = wr_en_q;
   assign wr_addr_ext_im = wr_addr_q;
   assign wr_data_ext_im = wr_data_q;
   assign error          = error_q;

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: directed and random loads
// against a list-based model of the expected memory writes.
module tb_im_loader;

   logic        clk;
   logic        reset;
   logic        start;
   logic        s_valid;
   logic [31:0] s_data;
   logic        s_ready;
   logic [31:0] wr_addr_ext_im;
   logic [31:0] wr_data_ext_im;
   logic        wr_en_ext_im;
   logic        busy;
   logic        done;
   logic        error;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int done_n = 0;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   int          wc_q[$];
   logic [31:0] dq[$];

`ifdef IM_LOAD_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   im_loader dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .s_valid        (s_valid),
      .s_data         (s_data),
      .s_ready        (s_ready),
      .wr_addr_ext_im (wr_addr_ext_im),
      .wr_data_ext_im (wr_data_ext_im),
      .wr_en_ext_im   (wr_en_ext_im),
      .busy           (busy),
      .done           (done),
      .error          (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every memory write strobe and every done pulse
   always @(negedge clk) begin
      if (wr_en_ext_im) begin
         wa_q.push_back(wr_addr_ext_im);
         wd_q.push_back(wr_data_ext_im);
         wc_q.push_back(cyc);
      end
      if (done) done_n <= done_n + 1;
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one word after a gap; returns just after the handshake edge
   task automatic push_word(input logic [31:0] w, input int gap);
      int n;
      s_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         start = 1'($urandom_range(0, 1));
         step();
      end
      start   = 1'b0;
      s_data  = w;
      s_valid = 1'b1;
      n = 0;
      while (!s_ready && n < 50) begin
         step();
         n++;
      end
      if (!s_ready) chk("ready_timeout", 0, 1);
      step();
      s_valid = 1'b0;
   endtask

   function automatic int rgap(input int gmax);
      return (gmax == 0) ? 0 : int'($urandom_range(0, gmax));
   endfunction

   // One full load; expectations come from the write list built here
   task automatic run_load(input int base, input int count,
                           input int gmax, input bit bad);
      logic [15:0] b16;
      logic [15:0] c16;
      logic [31:0] x;
      logic [31:0] ea[$];
      logic [31:0] ed[$];
      bit          err;
      bit          err_cs;
      int          d0;
      b16 = 16'(base);
      c16 = 16'(count);
      err = (base + count) > 64;
      err_cs = 1'b0;
      x = '0;
      if (!err) begin
         for (int i = 0; i < count; i++) begin
            ea.push_back(32'(base + i));
            ed.push_back(dq[i]);
            x = x ^ dq[i];
         end
      end
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      d0 = done_n;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", busy, 1);
      chk("ready_after_start", s_ready, 1);
      chk("error_cleared", error, 0);
      push_word({b16, c16}, rgap(gmax));
      if (!err) begin
         for (int i = 0; i < count; i++) push_word(dq[i], rgap(gmax));
         if (CS) begin
            if (bad) push_word((x == 0) ? 32'hFFFF_FFFF : 32'h0, rgap(gmax));
            else     push_word(x, rgap(gmax));
            err_cs = bad;
         end
      end
      chk("done_at_end", done, 1);
      chk("busy_at_end", busy, 0);
      chk("ready_at_end", s_ready, 0);
      chk("error_at_end", error, err | err_cs);
      chk("wr_en_at_done", wr_en_ext_im, !err && count > 0 && !CS);
      step();
      chk("done_one_cycle", done, 0);
      chk("done_count", done_n - d0, 1);
      chk("write_count", wa_q.size(), ea.size());
      for (int i = 0; i < ea.size() && i < wa_q.size(); i++)
         chk($sformatf("write[%0d]", i), {wa_q[i], wd_q[i]}, {ea[i], ed[i]});
      if (gmax == 0 && ea.size() > 1 && wc_q.size() == ea.size())
         chk("back_to_back", wc_q[wc_q.size()-1] - wc_q[0], ea.size() - 1);
   endtask

   task automatic fill(input int n, input bit ramp);
      dq.delete();
      for (int i = 0; i < n; i++) dq.push_back(ramp ? 32'(i) : $urandom);
   endtask

   initial begin
      reset   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      repeat (3) step();
      chk("rst_ready", s_ready, 0);
      chk("rst_wr_en", wr_en_ext_im, 0);
      chk("rst_wr_addr", wr_addr_ext_im, 0);
      chk("rst_wr_data", wr_data_ext_im, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_error", error, 0);
      reset = 1'b1;
      step();

      fill(64, 1'b1);
      run_load(0, 64, 0, 1'b0);

      fill(4, 1'b0);
      run_load(30, 4, 3, 1'b0);

      fill(5, 1'b0);
      run_load(60, 5, 0, 1'b0);
      fill(3, 1'b0);
      run_load(1, 3, 0, 1'b0);

      dq.delete();
      dq.push_back(32'hA5A5_0000);
      dq.push_back(32'h0000_5A5A);
      run_load(10, 2, 0, 1'b0);
      run_load(10, 2, 0, 1'b1);
      run_load(0, 0, 0, 1'b0);
      run_load(64, 0, 1, 1'b0);

      fill(8, 1'b0);
      start = 1'b1;
      step();
      start = 1'b0;
      wa_q.delete();
      wd_q.delete();
      wc_q.delete();
      push_word({16'd0, 16'd8}, 0);
      for (int i = 0; i < 3; i++) push_word(dq[i], 0);
      step();
      chk("partial_writes", wa_q.size(), 3);
      reset = 1'b0;
      #1;
      chk("midrst_ready", s_ready, 0);
      chk("midrst_wr_en", wr_en_ext_im, 0);
      chk("midrst_wr_addr", wr_addr_ext_im, 0);
      chk("midrst_wr_data", wr_data_ext_im, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_error", error, 0);
      step();
      reset = 1'b1;
      step();
      run_load(0, 8, 0, 1'b0);

      for (int r = 0; r < 12; r++) begin
         int b;
         int c;
         b = int'($urandom_range(0, 70));
         c = int'($urandom_range(0, 20));
         fill(c, 1'b0);
         run_load(b, c, int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
